// File: rtl/enc_r.sv
// enc_r: R-type instruction encoder with a small output FIFO.
//   Maps an internal 8-bit instruction code plus register/shift fields to a
//   32-bit MIPS R-type word {6'b0, rs, rt, rd, shamt, funct}. Encoded words
//   are queued in a DEPTH-entry FIFO and delivered over valid/ready.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         request handshake (in_ready = FIFO not full)
//   in_inst                   internal instruction code
//   in_reg_s/t/d, in_shift    rs, rt, rd, shamt fields
//   out_valid/out_ready       encoded-word handshake
//   out_code                  head entry while out_valid, else 0
//   out_count                 FIFO occupancy
//   err_pulse                 one-cycle pulse after an unknown code is accepted
//   err_count                 saturating count of accepted unknown codes
module enc_r #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_inst,
  input  logic [4:0]               in_reg_s,
  input  logic [4:0]               in_reg_t,
  input  logic [4:0]               in_reg_d,
  input  logic [4:0]               in_shift,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_code,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     err_pulse,
  output logic [CNT_W-1:0]         err_count
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned WORD_W = 32;

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];
  logic              err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  logic              known_c;
  logic [5:0]        funct_c;
  logic [4:0]        rs_c, rt_c, rd_c, sh_c;
  logic [WORD_W-1:0] word_c;
  logic              full_c, empty_c, accept_c, push_c, pop_c;

  // Code table lookup and per-class field forcing.
  always_comb begin
    known_c = 1'b1;
    funct_c = 6'h00;
    rs_c    = in_reg_s;
    rt_c    = in_reg_t;
    rd_c    = in_reg_d;
    sh_c    = 5'd0;
    case (in_inst)
      8'h01: funct_c = 6'h20;
      8'h02: funct_c = 6'h21;
      8'h03: funct_c = 6'h22;
      8'h04: funct_c = 6'h23;
      8'h05: funct_c = 6'h24;
      8'h06: funct_c = 6'h25;
      8'h07: funct_c = 6'h26;
      8'h08: funct_c = 6'h27;
      8'h09: funct_c = 6'h2A;
      8'h0A: funct_c = 6'h2B;
      8'h0B: begin funct_c = 6'h00; rs_c = 5'd0; sh_c = in_shift; end
      8'h0C: begin funct_c = 6'h02; rs_c = 5'd0; sh_c = in_shift; end
      8'h0D: begin funct_c = 6'h03; rs_c = 5'd0; sh_c = in_shift; end
      8'h0E: funct_c = 6'h04;
      8'h0F: funct_c = 6'h06;
      8'h10: funct_c = 6'h07;
      8'h11: begin funct_c = 6'h08; rt_c = 5'd0; rd_c = 5'd0; end
      default: known_c = 1'b0;
    endcase
    word_c = {6'b0, rs_c, rt_c, rd_c, sh_c, funct_c};
  end

  // FIFO control: status comes only from the registered pointers.
  always_comb begin
    empty_c  = (wptr_q == rptr_q);
    full_c   = (wptr_q[IDX_W] != rptr_q[IDX_W]) &&
               (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
    accept_c = in_valid && !full_c;
    push_c   = accept_c && known_c;
    pop_c    = !empty_c && out_ready;

    wptr_d = wptr_q + PTR_W'(push_c);
    rptr_d = rptr_q + PTR_W'(pop_c);

    mem_d = mem_q;
    if (push_c) begin
      mem_d[wptr_q[IDX_W-1:0]] = word_c;
    end

    err_pulse_d = accept_c && !known_c;
    err_count_d = err_count_q;
    if (err_pulse_d && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      mem_q       <= mem_d;
    end
  end

  // Output decode of registered state; no path from inputs to outputs.
  always_comb begin
    in_ready  = !full_c;
    out_valid = !empty_c;
    out_code  = empty_c ? '0 : mem_q[rptr_q[IDX_W-1:0]];
    out_count = wptr_q - rptr_q;
    err_pulse = err_pulse_q;
    err_count = err_count_q;
  end

endmodule

// File: tb/tb_enc_r.sv
// tb_enc_r: directed and randomized bench for enc_r against a queue-based
// reference model.
module tb_enc_r;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_inst;
  logic [4:0]  in_reg_s, in_reg_t, in_reg_d, in_shift;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_code;
  logic [2:0]  out_count;
  logic        err_pulse;
  logic [7:0]  err_count;

  enc_r #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_reg_s(in_reg_s), .in_reg_t(in_reg_t), .in_reg_d(in_reg_d),
    .in_shift(in_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_count(out_count), .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] mq[$];
  int          m_err   = 0;
  bit          m_pulse = 1'b0;
  int          ftab[17] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 8};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ref_enc(input int code, input int s, input int t, input int d,
                                 input int sh, output logic [31:0] w);
    int f;
    if (code < 1 || code > 17) begin
      w = 0;
      return 1'b0;
    end
    f = ftab[code-1];
    if (code >= 11 && code <= 13) s = 0;
    else if (code == 17) begin t = 0; d = 0; sh = 0; end
    else sh = 0;
    w = 32'(s * (1 << 21) + t * (1 << 16) + d * (1 << 11) + sh * (1 << 6) + f);
    return 1'b1;
  endfunction

  task automatic check_all(input string tag);
    int n = mq.size();
    check({tag, "/valid"}, 32'(out_valid), 32'(n > 0));
    check({tag, "/code"},  out_code, (n > 0) ? mq[0] : 32'h0);
    check({tag, "/count"}, 32'(out_count), 32'(n));
    check({tag, "/ready"}, 32'(in_ready), 32'(n < int'(DEPTH)));
    check({tag, "/epulse"}, 32'(err_pulse), 32'(m_pulse));
    check({tag, "/ecount"}, 32'(err_count), 32'(m_err));
  endtask

  // One clock: model decides from pre-edge inputs, then outputs are compared.
  task automatic step(input string tag);
    logic [31:0] w;
    bit known, acc, pop;
    known = ref_enc(int'(in_inst), int'(in_reg_s), int'(in_reg_t), int'(in_reg_d),
                    int'(in_shift), w);
    acc = in_valid && (mq.size() < int'(DEPTH));
    pop = out_ready && (mq.size() > 0);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc && known) mq.push_back(w);
    m_pulse = acc && !known;
    if (m_pulse && m_err < 255) m_err++;
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input logic [7:0] code, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh);
    in_valid = v; in_inst = code;
    in_reg_s = s; in_reg_t = t; in_reg_d = d; in_shift = sh;
  endtask

  task automatic rand_fields(input bit v);
    logic [7:0] code;
    code = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(1, 17));
    drive(v, code, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
  endtask

  initial begin
    int exp_rd;
    int pops;
    bit fifth_done;
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 5'd0);
    #12;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    check_all("post_reset");

    // ADD with shamt forced to zero.
    drive(1'b1, 8'h01, 5'd1, 5'd2, 5'd3, 5'd9);
    step("add");
    check("add_word", out_code, 32'h00221820);
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 5'd0);
    out_ready = 1'b1;
    step("add_drain");

    // SLL forces rs; JR forces rt/rd/shamt.
    out_ready = 1'b0;
    drive(1'b1, 8'h0B, 5'd9, 5'd5, 5'd4, 5'd7);
    step("sll");
    check("sll_word", out_code, 32'h000521C0);
    drive(1'b1, 8'h11, 5'd31, 5'd3, 5'd3, 5'd5);
    step("jr");
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 5'd0);
    out_ready = 1'b1;
    step("sll_pop");
    check("jr_word", out_code, 32'h03E00008);
    step("jr_pop");

    // Unknown code: no push, single error pulse, saturating counter.
    drive(1'b1, 8'hFF, 5'd1, 5'd1, 5'd1, 5'd1);
    step("unk");
    check("unk_pulse", 32'(err_pulse), 32'd1);
    check("unk_count", 32'(err_count), 32'd1);
    check("unk_nopush", 32'(out_count), 32'd0);
    drive(1'b0, 8'hFF, 5'd1, 5'd1, 5'd1, 5'd1);
    step("unk_idle");
    check("unk_pulse_off", 32'(err_pulse), 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      if (m_err < 255) m_err++;
    end
    m_pulse = 1'b1;
    check_all("unk_sat");
    check("unk_sat_val", 32'(err_count), 32'hFF);
    in_valid = 1'b0;
    step("unk_sat_idle");

    // Fill to full, stall a fifth request, then drain in order.
    out_ready = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      drive(1'b1, 8'h01, 5'd2, 5'd3, 5'(d), 5'd0);
      step("fill");
    end
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(out_count), 32'd4);
    drive(1'b1, 8'h01, 5'd2, 5'd3, 5'd5, 5'd0);
    step("stall");
    check("stall_count", 32'(out_count), 32'd4);
    out_ready = 1'b1;
    exp_rd = 1;
    pops = 0;
    fifth_done = 1'b0;
    for (int c = 0; c < 20 && pops < 5; c++) begin
      if (out_valid) begin
        check("drain_rd", 32'(out_code[15:11]), 32'(exp_rd));
        exp_rd++;
        pops++;
      end
      if (in_valid && in_ready) fifth_done = 1'b1;
      step("drain");
      if (fifth_done) in_valid = 1'b0;
    end
    check("drain_pops", 32'(pops), 32'd5);

    // Steady stream: one word in and one out per cycle once primed.
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 8'($urandom_range(1, 17)), 5'($urandom), 5'($urandom),
            5'($urandom), 5'($urandom));
      step("stream");
      check("stream_count", 32'(out_count), 32'd1);
    end
    in_valid = 1'b0;
    step("stream_end");

    // Asynchronous reset with entries queued.
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 8'h06, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0);
      step("prerst");
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    mq.delete();
    m_pulse = 1'b0;
    m_err   = 0;
    check_all("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 8'h07, 5'd4, 5'd5, 5'd6, 5'd0);
    step("after_rst");
    check("after_rst_word", out_code, 32'h00853026);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step("after_rst_pop");

    // Randomized traffic.
    for (int c = 0; c < 500; c++) begin
      rand_fields(1'($urandom));
      out_ready = 1'($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
